bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//  Two-master bus arbiter placed directly downstream of the DMA bus master port.
//  Shares one slave-side bus between master 0 (CPU data port) and master 1 (DMA).
//  Round-robin on contention; grant held for the whole request/ready/release handshake.
//  Forwards the selected master's signals unchanged, so the slave sees one plain master.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles a granted request may wait for i_bus_ready (BUS_ARBITER_TIMEOUT_EN only)
// PORTS
//  i_clock        in   1   single clock; all state changes on posedge
//  i_reset        in   1   asynchronous, active-high reset
//  i_m0_request   in   1   master 0 request; held until ready seen (or abandoned)
//  i_m0_rw        in   1   master 0: 1=write, 0=read
//  i_m0_address   in   32  master 0 address
//  i_m0_wdata     in   32  master 0 write data
//  o_m0_rdata     out  32  master 0 read data
//  o_m0_ready     out  1   master 0 ready
//  i_m1_request/i_m1_rw/i_m1_address/i_m1_wdata/o_m1_rdata/o_m1_ready: same, master 1 (DMA)
//  o_bus_request  out  1   slave request
//  o_bus_rw       out  1   slave read/write
//  o_bus_address  out  32  slave address
//  o_bus_wdata    out  32  slave write data
//  i_bus_ready    in   1   slave ready; slave drops it only after request drops
//  i_bus_rdata    in   32  slave read data
//  o_timeout      out  1   one-cycle pulse when a transaction is abandoned by timeout
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (m0 wins first tie), counter=0; every output 0.
//  States: IDLE, GRANT0, GRANT1, RELEASE. State registered, bus mux combinational on state.
//  IDLE: only m0 req -> GRANT0; only m1 req -> GRANT1; both -> master != last_grant; none -> stay.
//  Latency: request sampled in IDLE on edge N; o_bus_request high during cycle N+1.
//  GRANTx: o_bus_* = master x inputs; o_mx_ready=i_bus_ready; o_mx_rdata=i_bus_rdata.
//   Non-granted master: ready=0, rdata=0. Changes on its inputs are ignored.
//   !i_mx_request (normal end after ready, or early abandon) -> RELEASE; last_grant<=x.
//  RELEASE: o_bus_request=0, both readies 0; stay while i_bus_ready=1; i_bus_ready=0 -> IDLE.
//   This prevents a stale ready reaching the next master.
//  Re-arbitration gap: min 2 cycles (RELEASE, IDLE) between grants. DMA F_INTERLEAVE
//   therefore always yields to a pending m0.
//  Fairness: persistent requests from both masters strictly alternate.
//  Reset mid-transaction: outputs drop asynchronously and the transaction is lost.
//   Masters must restart it; arbitration restarts with m0 priority.
//  Simultaneous request fall and ready rise in GRANTx: the request fall wins -> RELEASE.
// CONFIGURATION
//  BUS_ARBITER_TIMEOUT_EN defined:
//   16-bit counter cleared on GRANT entry; counts GRANTx cycles with request=1, ready=0.
//   Counter==TIMEOUT_CYCLES-1:
//    force o_bus_request=0; o_mx_ready=1; o_mx_rdata=32'hFFFF_FFFF until master drops request.
//    o_timeout=1 for exactly that first cycle; then normal RELEASE.
//  Undefined: no counter; grant waits indefinitely; o_timeout tied 0.
// TESTING
//  1 m0 read 0x0000_0100, slave ready 3 cycles later, rdata 0x1234_5678
//    -> o_m0_ready=1, o_m0_rdata=0x1234_5678, o_m1_ready=0 throughout.
//  2 from reset, m0 (write 0x10) and m1 (write 0x20) request in same cycle
//    -> bus address 0x10 first, then 0x20.
//  3 m1 re-requests 1 cycle after each release (8 words); m0 issues 4 reads
//    -> bus order m1,m0,m1,m0,... while both pending.
//  4 slave holds ready 2 cycles after m0 drops request, m1 pending
//    -> o_bus_request stays 0 until ready low, m1 granted 2 cycles later.
//  5 BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ready, m1 read
//    -> 16th grant cycle: o_m1_ready=1, rdata 0xFFFF_FFFF, single o_timeout pulse.
//  6 i_reset pulsed while in GRANT1 -> all outputs 0 same cycle;
//    afterwards both request -> m0 granted.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter; the grant is held for the whole request/ready/release handshake.
// Define BUS_ARBITER_TIMEOUT_EN to build the abandon-on-timeout logic (TIMEOUT_CYCLES).
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_m0_request,
    input  logic        i_m0_rw,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_wdata,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_ready,
    input  logic        i_m1_request,
    input  logic        i_m1_rw,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_ready,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT0  = 2'd1;
    localparam logic [1:0] ST_GRANT1  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       granted;
    logic       gnt_sel;
    logic       gnt_req;
    logic       timeout_hit;
    logic       timeout_pulse;

    assign granted = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    assign gnt_sel = (state_q == ST_GRANT1);
    assign gnt_req = gnt_sel ? i_m1_request : i_m0_request;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q, count_d;
    logic        timed_out_q, timed_out_d;

    // Forcing lasts only while the master still holds its request.
    assign timeout_hit   = granted && gnt_req && (timed_out_q || (count_q == COUNT_LAST));
    assign timeout_pulse = granted && gnt_req && !timed_out_q && (count_q == COUNT_LAST);

    always_comb begin
        count_d     = count_q;
        timed_out_d = timed_out_q;
        if (!granted) begin
            count_d     = '0;
            timed_out_d = 1'b0;
        end else if (timeout_pulse) begin
            timed_out_d = 1'b1;
        end else if (!timed_out_q && gnt_req && !i_bus_ready) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count_q     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            timed_out_q <= timed_out_d;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (i_m0_request && (!i_m1_request || last_grant_q))
                    state_d = ST_GRANT0;
                else if (i_m1_request)
                    state_d = ST_GRANT1;
            end
            ST_GRANT0, ST_GRANT1: begin
                // A request fall wins over a simultaneous ready rise.
                if (!gnt_req) begin
                    state_d      = ST_RELEASE;
                    last_grant_d = gnt_sel;
                end
            end
            ST_RELEASE: begin
                if (!i_bus_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = '0;
        o_bus_wdata   = '0;
        o_m0_ready    = 1'b0;
        o_m0_rdata    = '0;
        o_m1_ready    = 1'b0;
        o_m1_rdata    = '0;
        if (granted) begin
            o_bus_request = gnt_req && !timeout_hit;
            o_bus_rw      = gnt_sel ? i_m1_rw      : i_m0_rw;
            o_bus_address = gnt_sel ? i_m1_address : i_m0_address;
            o_bus_wdata   = gnt_sel ? i_m1_wdata   : i_m0_wdata;
            if (gnt_sel) begin
                o_m1_ready = i_bus_ready || timeout_hit;
                o_m1_rdata = timeout_hit ? 32'hFFFF_FFFF : i_bus_rdata;
            end else begin
                o_m0_ready = i_bus_ready || timeout_hit;
                o_m0_rdata = timeout_hit ? 32'hFFFF_FFFF : i_bus_rdata;
            end
        end
    end

    assign o_timeout = timeout_pulse;

endmodule
